branch_predictor: RTL and testbench

- Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Sits in the fetch stage, upstream of the hazard unit.
- Supplies the taken/not-taken prediction and target for the current fetch PC.
- That prediction travels down the pipeline and becomes the hazard unit's prediction input; the hazard unit raises flush when the resolved branch outcome disagrees with it.
- Trained from the resolved-branch update port in EX/MEM.

---
 rtl/branch_predictor_if.sv | 32 +++
 rtl/branch_predictor.sv | 77 +++++++
 tb/tb_branch_predictor.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_if
// Purpose  : Fetch lookup and resolved-branch update bundle for the BTB.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] if_pc_in;
  logic             prediction_out;
  logic [WIDTH-1:0] pred_target_out;
  logic             update_valid_in;
  logic [WIDTH-1:0] update_pc_in;
  logic             update_taken_in;
  logic [WIDTH-1:0] update_target_in;
  logic             update_pred_in;
  logic [31:0]      mispred_count_out;

  modport master (
    output if_pc_in, update_valid_in, update_pc_in, update_taken_in,
           update_target_in, update_pred_in,
    input  prediction_out, pred_target_out, mispred_count_out
  );

  modport slave (
    input  if_pc_in, update_valid_in, update_pc_in, update_taken_in,
           update_target_in, update_pred_in,
    output prediction_out, pred_target_out, mispred_count_out
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BTB with 2-bit saturating counters and a
//            saturating mispredict counter.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int WIDTH      = 32,
  parameter int ENTRY_BITS = 4
) (
  input  wire logic         clk_in,
  input  wire logic         rst_in,
  branch_predictor_if.slave bp
);
  localparam int c_entries = 1 << ENTRY_BITS;
  localparam int c_tag_w   = WIDTH - ENTRY_BITS - 2;

  logic                  r_valid  [c_entries];
  logic [c_tag_w-1:0]    r_tag    [c_entries];
  logic [WIDTH-1:0]      r_target [c_entries];
  logic [1:0]            r_ctr    [c_entries];
  logic [31:0]           r_mispred_count;

  logic [ENTRY_BITS-1:0] w_idx;
  logic [c_tag_w-1:0]    w_tag;
  logic                  w_hit;
  logic [ENTRY_BITS-1:0] w_uidx;
  logic [c_tag_w-1:0]    w_utag;
  logic                  w_uhit;
  logic                  w_unused_pc_lsbs;

  // Byte offset within the instruction word plays no part in indexing.
  assign w_unused_pc_lsbs = ^{bp.if_pc_in[1:0], bp.update_pc_in[1:0]};

  assign w_idx  = bp.if_pc_in[ENTRY_BITS+1:2];
  assign w_tag  = bp.if_pc_in[WIDTH-1:ENTRY_BITS+2];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign w_uidx = bp.update_pc_in[ENTRY_BITS+1:2];
  assign w_utag = bp.update_pc_in[WIDTH-1:ENTRY_BITS+2];
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

  assign bp.prediction_out    = w_hit & r_ctr[w_idx][1];
  assign bp.pred_target_out   = w_hit ? r_target[w_idx] : '0;
  assign bp.mispred_count_out = r_mispred_count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < c_entries; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_mispred_count <= '0;
    end else if (bp.update_valid_in) begin
      if (w_uhit) begin
        if (bp.update_taken_in) begin
          if (r_ctr[w_uidx] != 2'b11) r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
          r_target[w_uidx] <= bp.update_target_in;
        end else if (r_ctr[w_uidx] != 2'b00) begin
          r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
        end
      end else if (bp.update_taken_in) begin
        // Taken miss evicts whatever lives at this index.
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= bp.update_target_in;
        r_ctr[w_uidx]    <= 2'b10;
      end
      if ((bp.update_taken_in != bp.update_pred_in) && (r_mispred_count != 32'hFFFF_FFFF))
        r_mispred_count <= r_mispred_count + 32'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed table, corner sequences and random run against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.WIDTH(32)) bp_if ();

  branch_predictor #(.WIDTH(32), .ENTRY_BITS(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bp     (bp_if)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: plain arrays indexed by word address modulo entry count.
  bit          m_valid [16];
  longint      m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_cnt;

  function automatic int midx(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic longint mtag(logic [31:0] pc);
    return longint'(pc >> 6);
  endfunction

  function automatic bit mhit(logic [31:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  task automatic model_edge();
    int i;
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 1;
      end
      m_cnt = 0;
    end else if (bp_if.update_valid_in) begin
      i = midx(bp_if.update_pc_in);
      if (mhit(bp_if.update_pc_in)) begin
        if (bp_if.update_taken_in) begin
          m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = bp_if.update_target_in;
        end else begin
          m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (bp_if.update_taken_in) begin
        m_valid[i] = 1; m_tag[i] = mtag(bp_if.update_pc_in);
        m_tgt[i] = bp_if.update_target_in; m_ctr[i] = 2;
      end
      if (bp_if.update_taken_in != bp_if.update_pred_in)
        m_cnt = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
    end
  endtask

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after a rising edge; outputs settle by the falling edge.
  task automatic drive(bit r, bit uv, logic [31:0] upc, bit ut, logic [31:0] utgt,
                       bit upred, logic [31:0] lpc);
    rst                    = r;
    bp_if.update_valid_in  = uv;
    bp_if.update_pc_in     = upc;
    bp_if.update_taken_in  = ut;
    bp_if.update_target_in = utgt;
    bp_if.update_pred_in   = upred;
    bp_if.if_pc_in         = lpc;
    #4;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(string tag);
    logic [31:0] lpc;
    lpc = bp_if.if_pc_in;
    check({tag, "_pred"}, longint'(bp_if.prediction_out),
          longint'(mhit(lpc) && m_ctr[midx(lpc)] >= 2));
    check({tag, "_tgt"}, longint'(bp_if.pred_target_out),
          mhit(lpc) ? longint'(m_tgt[midx(lpc)]) : 64'd0);
    check({tag, "_cnt"}, longint'(bp_if.mispred_count_out), m_cnt);
  endtask

  typedef struct {
    bit          r;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utgt;
    bit          upred;
    logic [31:0] lpc;
    bit          ep;
    logic [31:0] et;
    logic [31:0] ec;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(bit r, bit uv, logic [31:0] upc, bit ut, logic [31:0] utgt,
                              bit upred, logic [31:0] lpc, bit ep, logic [31:0] et,
                              logic [31:0] ec);
    vec_t v;
    v.r = r; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upred = upred;
    v.lpc = lpc; v.ep = ep; v.et = et; v.ec = ec;
    return v;
  endfunction

  initial begin
    // Expected outputs are the pre-edge view of each row's lookup.
    tbl[0]  = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h40,   0, 32'h0,   0);
    tbl[1]  = mk(0, 1, 32'h40,   1, 32'h100,  0, 32'h40,   0, 32'h0,   0);
    tbl[2]  = mk(0, 1, 32'h40,   1, 32'h100,  1, 32'h40,   1, 32'h100, 1);
    tbl[3]  = mk(0, 1, 32'h40,   1, 32'h100,  1, 32'h40,   1, 32'h100, 1);
    tbl[4]  = mk(0, 1, 32'h40,   1, 32'h100,  1, 32'h40,   1, 32'h100, 1);
    tbl[5]  = mk(0, 1, 32'h40,   0, 32'h0,    1, 32'h40,   1, 32'h100, 1);
    tbl[6]  = mk(0, 1, 32'h40,   0, 32'h0,    1, 32'h40,   1, 32'h100, 2);
    tbl[7]  = mk(0, 1, 32'h40,   0, 32'h0,    0, 32'h40,   0, 32'h100, 3);
    tbl[8]  = mk(0, 1, 32'h40,   0, 32'h0,    0, 32'h40,   0, 32'h100, 3);
    tbl[9]  = mk(0, 1, 32'h40,   1, 32'h104,  0, 32'h40,   0, 32'h100, 3);
    tbl[10] = mk(0, 1, 32'h40,   1, 32'h104,  0, 32'h40,   0, 32'h104, 4);
    tbl[11] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h80,   0, 32'h0,   5);
    tbl[12] = mk(0, 1, 32'h80,   0, 32'h0,    0, 32'h40,   1, 32'h104, 5);
    tbl[13] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h40,   1, 32'h104, 5);
    tbl[14] = mk(0, 1, 32'h80,   1, 32'h200,  0, 32'h80,   0, 32'h0,   5);
    tbl[15] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h40,   0, 32'h0,   6);
    tbl[16] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h80,   1, 32'h200, 6);
    tbl[17] = mk(0, 0, 32'h80,   0, 32'hDEAD, 1, 32'h80,   1, 32'h200, 6);
    tbl[18] = mk(1, 1, 32'h1000, 1, 32'h300,  0, 32'h1000, 0, 32'h0,   6);
    tbl[19] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h1000, 0, 32'h0,   0);
    tbl[20] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h80,   0, 32'h0,   0);
    tbl[21] = mk(0, 1, 32'h43,   1, 32'h50,   1, 32'h42,   0, 32'h0,   0);
    tbl[22] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h41,   1, 32'h50,  0);

    drive(1, 0, 0, 0, 0, 0, 32'h40);
    advance();
    advance();

    for (int n = 0; n < NV; n++) begin
      drive(tbl[n].r, tbl[n].uv, tbl[n].upc, tbl[n].ut, tbl[n].utgt, tbl[n].upred,
            tbl[n].lpc);
      check($sformatf("vec%0d_pred", n), longint'(bp_if.prediction_out), longint'(tbl[n].ep));
      check($sformatf("vec%0d_tgt", n), longint'(bp_if.pred_target_out), longint'(tbl[n].et));
      check($sformatf("vec%0d_cnt", n), longint'(bp_if.mispred_count_out), longint'(tbl[n].ec));
      advance();
    end

    // Counter saturation: preload near the top, then push past it.
    drive(0, 0, 0, 0, 0, 0, 32'h40);
    force dut.r_mispred_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_mispred_count;
    m_cnt = 64'hFFFF_FFFE;
    check("sat_preload", longint'(bp_if.mispred_count_out), 64'hFFFF_FFFE);
    advance();
    drive(0, 1, 32'h200, 1, 32'h10, 0, 32'h200);
    advance();
    drive(0, 1, 32'h200, 0, 32'h0, 1, 32'h200);
    check("sat_reach", longint'(bp_if.mispred_count_out), 64'hFFFF_FFFF);
    advance();
    drive(0, 1, 32'h200, 1, 32'h10, 0, 32'h200);
    check("sat_hold1", longint'(bp_if.mispred_count_out), 64'hFFFF_FFFF);
    advance();
    drive(0, 0, 0, 0, 0, 0, 32'h200);
    check("sat_hold2", longint'(bp_if.mispred_count_out), 64'hFFFF_FFFF);
    check_model("sat_model");
    advance();

    // Random traffic over a few tags so hits, aliases and evictions occur.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] upc, lpc;
      upc = {$urandom_range(0, 3), 6'd0} | ({28'd0, 4'($urandom_range(0, 15))} << 2)
            | 32'($urandom_range(0, 3));
      lpc = ($urandom_range(0, 1) == 1) ? upc
            : ({$urandom_range(0, 3), 6'd0} | ({28'd0, 4'($urandom_range(0, 15))} << 2));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), upc,
            1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), lpc);
      check_model($sformatf("rnd%0d", n));
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
